// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    EXT_NONE = 3'b000,
    EXT_S    = 3'b001,
    EXT_I    = 3'b010,
    EXT_B    = 3'b100
  } ext_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Immediate format implied by the opcode; R-type and unknowns need none.
  function automatic ext_op_e ext_of(input logic [6:0] op);
    case (op)
      OP_IALU, OP_LOAD: return EXT_I;
      OP_STORE:         return EXT_S;
      OP_BRANCH:        return EXT_B;
      default:          return EXT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Datapath/memory side of the sequencer: decode fields in, strobes out.
interface mc_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_sel;
  logic        mem_we;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        ab_we;
  logic        aluout_we;
  logic        mdr_we;
  logic        rf_we;
  logic        wd_sel;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic [2:0]  ext_op;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  modport master (
    input  opcode, funct3, funct7_5, alu_zero, mem_ready,
    output mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel, ab_we, aluout_we,
           mdr_we, rf_we, wd_sel, alu_src_b, alu_op, ext_op, trap, trap_cause,
           instret
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_zero, mem_ready,
    input  mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel, ab_we, aluout_we,
           mdr_we, rf_we, wd_sel, alu_src_b, alu_op, ext_op, trap, trap_cause,
           instret
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decode from opcode/funct3/funct7_5; flags reserved branch funct3.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op,
  output logic       br_bad
);

  // R and I-ALU share the funct3 map; only R-type may select SUB.
  always_comb begin
    alu_op = ALU_ADD;
    br_bad = 1'b0;
    case (opcode)
      OP_R, OP_IALU: begin
        case (funct3)
          3'b000: alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        br_bad = 1'b1;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap
// and retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        rstn,
  mc_ctrl_if.master  bus
);

  state_e      state, state_nx;
  logic [15:0] wait_cnt;
  logic [31:0] instret_q;
  logic        trap_q;
  cause_e      cause_q, cause_nx;
  logic        go_trap, retire;

  logic        ir_we, pc_we, pc_sel, ab_we, aluout_we, mdr_we, rf_we, wd_sel;
  logic        alu_src_b;
  alu_op_e     alu_op, dec_op;
  logic        br_bad, taken, req_st, timeout_hit;
  logic        is_r, is_load, is_store, is_branch;

  mc_alu_dec u_dec (
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .alu_op   (dec_op),
    .br_bad   (br_bad)
  );

  assign is_r      = (bus.opcode == OP_R);
  assign is_load   = (bus.opcode == OP_LOAD);
  assign is_store  = (bus.opcode == OP_STORE);
  assign is_branch = (bus.opcode == OP_BRANCH);

  // beq/bge/bgeu take on zero; bne/blt/bltu take on non-zero.
  assign taken = (bus.funct3[2] ^ bus.funct3[0]) ? !bus.alu_zero : bus.alu_zero;

  // Request strobes come from registered state only; reset kills them at once.
  assign req_st      = (state == S_FETCH) || (state == S_MEM);
  assign bus.mem_req = rstn & req_st;
  assign bus.mem_sel = (state == S_MEM);
  assign bus.mem_we  = rstn & (state == S_MEM) & is_store;

  // Last permitted wait cycle with no ready: ready in that cycle still wins.
  assign timeout_hit = req_st && !bus.mem_ready && (wait_cnt == 16'(TIMEOUT - 1));

  // Next-state and per-state strobes.
  always_comb begin
    state_nx  = state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    wd_sel    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    go_trap   = 1'b0;
    cause_nx  = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout_hit) begin
          go_trap  = 1'b1;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        if (!op_legal(bus.opcode)) begin
          go_trap  = 1'b1;
          cause_nx = CAUSE_ILLEGAL;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        aluout_we = 1'b1;
        alu_op    = dec_op;
        alu_src_b = !(is_r || is_branch);
        if (is_branch) begin
          if (br_bad) begin
            go_trap  = 1'b1;
            cause_nx = CAUSE_ILLEGAL;
          end else begin
            pc_we    = taken;
            pc_sel   = taken;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (is_load || is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (is_store) begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            mdr_we   = 1'b1;
            state_nx = S_WB;
          end
        end else if (timeout_hit) begin
          go_trap  = 1'b1;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wd_sel   = is_load;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
    if (go_trap) state_nx = S_TRAP;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Wait counter: runs while a request is unanswered, otherwise held at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          wait_cnt <= '0;
    else if (req_st && !bus.mem_ready)  wait_cnt <= wait_cnt + 16'd1;
    else                                wait_cnt <= '0;
  end

  // Sticky trap flag and cause.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (go_trap) begin
      trap_q  <= 1'b1;
      cause_q <= cause_nx;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.ab_we      = ab_we;
  assign bus.aluout_we  = aluout_we;
  assign bus.mdr_we     = mdr_we;
  assign bus.rf_we      = rf_we;
  assign bus.wd_sel     = wd_sel;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.ext_op     = (state == S_FETCH || state == S_TRAP) ? EXT_NONE
                                                                : ext_of(bus.opcode);
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle vector table through a scoreboard queue,
// then directed timeout / wrap / reset / bad-branch sequences.
module tb_mc_ctrl;

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] B_OP = 7'b1100011;
  localparam logic [6:0] J_OP = 7'b1101111;

  // Strobe order: req sel we ir pc_we pc_sel ab aluout mdr rf wd_sel src_b
  localparam logic [11:0] FW  = 12'b100000000000;
  localparam logic [11:0] F1  = 12'b100110000000;
  localparam logic [11:0] DEC = 12'b000000100000;
  localparam logic [11:0] EXR = 12'b000000010000;
  localparam logic [11:0] EXI = 12'b000000010001;
  localparam logic [11:0] BRT = 12'b000011010000;
  localparam logic [11:0] WBA = 12'b000000000100;
  localparam logic [11:0] WBL = 12'b000000000110;
  localparam logic [11:0] MW  = 12'b110000000000;
  localparam logic [11:0] ML  = 12'b110000001000;
  localparam logic [11:0] MS  = 12'b111000000000;
  localparam logic [11:0] TRP = 12'b000000000000;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [11:0] strb;
    logic [3:0]  aop;
    logic [2:0]  ext;
    logic        tr;
    logic [1:0]  cause;
    logic [31:0] ir;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  mc_ctrl_if bus();
  mc_ctrl #(.TIMEOUT(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic z, input logic rdy,
                              input logic [11:0] strb, input logic [3:0] aop,
                              input logic [2:0] ext, input logic tr,
                              input logic [1:0] cause, input logic [31:0] ir);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.strb = strb;
    v.aop = aop; v.ext = ext; v.tr = tr; v.cause = cause; v.ir = ir;
    return v;
  endfunction

  function automatic logic [11:0] strobes();
    return {bus.mem_req, bus.mem_sel, bus.mem_we, bus.ir_we, bus.pc_we,
            bus.pc_sel, bus.ab_we, bus.aluout_we, bus.mdr_we, bus.rf_we,
            bus.wd_sel, bus.alu_src_b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let logic settle.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy);
    @(negedge clk);
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f7;
    bus.alu_zero = z; bus.mem_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
    bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;

    // addi, zero-wait: F D E W
    tbl.push_back(mk(I_OP,0,0,0,1,F1 ,0,3'b000,0,0,0));
    tbl.push_back(mk(I_OP,0,0,0,0,DEC,0,3'b010,0,0,0));
    tbl.push_back(mk(I_OP,0,0,0,0,EXI,0,3'b010,0,0,0));
    tbl.push_back(mk(I_OP,0,0,0,0,WBA,0,3'b010,0,0,0));
    // sub, one fetch wait
    tbl.push_back(mk(R_OP,0,1,0,0,FW ,0,3'b000,0,0,1));
    tbl.push_back(mk(R_OP,0,1,0,1,F1 ,0,3'b000,0,0,1));
    tbl.push_back(mk(R_OP,0,1,0,0,DEC,0,3'b000,0,0,1));
    tbl.push_back(mk(R_OP,0,1,0,0,EXR,1,3'b000,0,0,1));
    tbl.push_back(mk(R_OP,0,1,0,0,WBA,0,3'b000,0,0,1));
    // lw, 3 data waits; ready lands exactly on the TIMEOUT boundary
    tbl.push_back(mk(L_OP,2,0,0,1,F1 ,0,3'b000,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,DEC,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,EXI,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,MW ,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,MW ,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,MW ,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,1,ML ,0,3'b010,0,0,2));
    tbl.push_back(mk(L_OP,2,0,0,0,WBL,0,3'b010,0,0,2));
    // bne, not zero -> taken
    tbl.push_back(mk(B_OP,1,0,0,1,F1 ,0,3'b000,0,0,3));
    tbl.push_back(mk(B_OP,1,0,0,0,DEC,0,3'b100,0,0,3));
    tbl.push_back(mk(B_OP,1,0,0,0,BRT,1,3'b100,0,0,3));
    // beq, not zero -> not taken
    tbl.push_back(mk(B_OP,0,0,0,1,F1 ,0,3'b000,0,0,4));
    tbl.push_back(mk(B_OP,0,0,0,0,DEC,0,3'b100,0,0,4));
    tbl.push_back(mk(B_OP,0,0,0,0,EXR,1,3'b100,0,0,4));
    // srai
    tbl.push_back(mk(I_OP,5,1,0,1,F1 ,0,3'b000,0,0,5));
    tbl.push_back(mk(I_OP,5,1,0,0,DEC,0,3'b010,0,0,5));
    tbl.push_back(mk(I_OP,5,1,0,0,EXI,7,3'b010,0,0,5));
    tbl.push_back(mk(I_OP,5,1,0,0,WBA,0,3'b010,0,0,5));
    // bgeu, zero -> taken
    tbl.push_back(mk(B_OP,7,0,1,1,F1 ,0,3'b000,0,0,6));
    tbl.push_back(mk(B_OP,7,0,1,0,DEC,0,3'b100,0,0,6));
    tbl.push_back(mk(B_OP,7,0,1,0,BRT,9,3'b100,0,0,6));
    // sw, zero-wait
    tbl.push_back(mk(S_OP,2,0,0,1,F1 ,0,3'b000,0,0,7));
    tbl.push_back(mk(S_OP,2,0,0,0,DEC,0,3'b001,0,0,7));
    tbl.push_back(mk(S_OP,2,0,0,0,EXI,0,3'b001,0,0,7));
    tbl.push_back(mk(S_OP,2,0,0,1,MS ,0,3'b001,0,0,7));
    // slt
    tbl.push_back(mk(R_OP,2,0,0,1,F1 ,0,3'b000,0,0,8));
    tbl.push_back(mk(R_OP,2,0,0,0,DEC,0,3'b000,0,0,8));
    tbl.push_back(mk(R_OP,2,0,0,0,EXR,8,3'b000,0,0,8));
    tbl.push_back(mk(R_OP,2,0,0,0,WBA,0,3'b000,0,0,8));
    // jal is unsupported -> trap after decode, instret frozen
    tbl.push_back(mk(J_OP,0,0,0,1,F1 ,0,3'b000,0,0,9));
    tbl.push_back(mk(J_OP,0,0,0,0,DEC,0,3'b000,0,0,9));
    tbl.push_back(mk(J_OP,0,0,0,0,TRP,0,3'b000,1,1,9));
    tbl.push_back(mk(J_OP,0,0,0,0,TRP,0,3'b000,1,1,9));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset mem_req low", 32'(bus.mem_req), 32'd0);
    rstn = 1'b1;
    #1;
    chk("reset strobes", 32'(strobes()), 32'(FW));
    chk("reset trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
    chk("reset instret", bus.instret, 32'd0);
    chk("reset ext_op", 32'(bus.ext_op), 32'd0);

    // Table through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
      sb.push_back(tbl[i]);
      e = sb.pop_front();
      chk($sformatf("v%0d strobes", i), 32'(strobes()), 32'(e.strb));
      chk($sformatf("v%0d ext_op", i), 32'(bus.ext_op), 32'(e.ext));
      chk($sformatf("v%0d trap", i), 32'({bus.trap, bus.trap_cause}), 32'({e.tr, e.cause}));
      chk($sformatf("v%0d instret", i), bus.instret, e.ir);
      if (e.strb[4]) chk($sformatf("v%0d alu_op", i), 32'(bus.alu_op), 32'(e.aop));
    end

    // Fetch timeout after 4 request cycles, then reset recovery
    @(negedge clk); rstn = 1'b0; #1;
    chk("rst clears trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
    chk("rst clears instret", bus.instret, 32'd0);
    @(negedge clk); rstn = 1'b1; bus.mem_ready = 1'b0; #1;
    chk("to req c1", 32'(bus.mem_req), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      step(R_OP, 0, 0, 0, 0);
      chk($sformatf("to req c%0d", k), 32'({bus.mem_req, bus.trap}), 32'b10);
    end
    step(R_OP, 0, 0, 0, 0);
    chk("to trap", 32'({bus.trap, bus.trap_cause}), 32'b110);
    chk("to req dropped", 32'(bus.mem_req), 32'd0);
    @(negedge clk); rstn = 1'b0; #1;
    chk("to rst trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("to restart req", 32'(strobes()), 32'(FW));

    // instret wrap on a store
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    bus.opcode = S_OP; bus.funct3 = 3'd2; bus.mem_ready = 1'b1; #1;
    chk("wrap preset", bus.instret, 32'hFFFF_FFFF);
    chk("wrap F we", 32'(bus.mem_we), 32'd0);
    step(S_OP, 2, 0, 0, 0);
    chk("wrap D we", 32'(bus.mem_we), 32'd0);
    step(S_OP, 2, 0, 0, 0);
    chk("wrap E we", 32'(bus.mem_we), 32'd0);
    step(S_OP, 2, 0, 0, 1);
    chk("wrap M req/sel/we", 32'({bus.mem_req, bus.mem_sel, bus.mem_we}), 32'b111);
    step(S_OP, 2, 0, 0, 0);
    chk("wrap instret", bus.instret, 32'd0);
    chk("wrap F2 we", 32'(bus.mem_we), 32'd0);

    // Reset in the middle of a store wait drops the request at once
    step(S_OP, 2, 0, 0, 1);
    step(S_OP, 2, 0, 0, 0);
    step(S_OP, 2, 0, 0, 0);
    step(S_OP, 2, 0, 0, 0);
    chk("mid-store we", 32'({bus.mem_req, bus.mem_we}), 32'b11);
    rstn = 1'b0; #1;
    chk("mid-store rst drop", 32'({bus.mem_req, bus.mem_we}), 32'b00);
    @(negedge clk); rstn = 1'b1; #1;

    // Reserved branch funct3 traps out of EXEC
    step(B_OP, 2, 0, 0, 1);
    step(B_OP, 2, 0, 0, 0);
    chk("bad br D no trap", 32'(bus.trap), 32'd0);
    step(B_OP, 2, 0, 0, 0);
    step(B_OP, 2, 0, 0, 0);
    chk("bad br trap", 32'({bus.trap, bus.trap_cause}), 32'b101);
    chk("bad br idle", 32'(strobes()), 32'(TRP));
    chk("bad br instret", bus.instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
